genius_round_engine: RTL

//  Parametrised Genius (Simon) game engine: one block holding the sequence memory, LFSR colour generator,

---
 rtl/genius_round_engine.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/genius_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : genius_round_engine
// Purpose  : Simon-style game engine: LFSR colour source, sequence memory,
//            timed playback, press checking, press timeout and scoring.
// Revision : 1.0 - initial release
// ============================================================================
module genius_round_engine #(
  parameter int          N_CH        = 4,
  parameter int          MAX_LEN     = 16,
  parameter int          ON_CYC      = 25_000_000,
  parameter int          OFF_CYC     = 12_500_000,
  parameter int          TIMEOUT_CYC = 250_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         LW          = $clog2(MAX_LEN + 1)
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            enter,
  input  logic            mode,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] leds,
  output logic [LW-1:0]   level,
  output logic [LW-1:0]   score,
  output logic [2:0]      state,
  output logic            win,
  output logic            lose,
  output logic            end_time
);

  localparam int          CW       = $clog2(N_CH);
  localparam int          IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [31:0] OFF_LAST = (OFF_CYC > 0) ? 32'(OFF_CYC - 1) : 32'd0;
  localparam logic [31:0] TO_LAST  = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN      = 3'd1,
    S_PLAY_ON  = 3'd2,
    S_PLAY_OFF = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_CHECK    = 3'd5,
    S_WIN      = 3'd6,
    S_LOSE     = 3'd7
  } state_t;

  state_t            st, st_n;
  logic [15:0]       lfsr;
  logic              enter_q, enter_prev;
  logic [N_CH-1:0]   btn_q, btn_prev;
  logic [IW-1:0]     idx, idx_n;
  logic [31:0]       timer, timer_n;
  logic [LW-1:0]     level_n, score_n;
  logic              win_n, lose_n, end_n;
  logic              mode_r, mode_n;
  logic [CW-1:0]     mem [MAX_LEN];

  logic              enter_edge;
  logic [N_CH-1:0]   btn_edge;
  logic [LW-1:0]     lvl_m1;
  logic              last_step;
  logic [CW-1:0]     colour;
  logic [N_CH-1:0]   exp_oh;
  logic [31:0]       shamt;
  logic [31:0]       t_on;

  function automatic logic [N_CH-1:0] onehot(input logic [CW-1:0] c);
    logic [N_CH-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Edges come from a registered copy so every input bit sees the same one-cycle latency.
  assign enter_edge = enter_q & ~enter_prev;
  assign btn_edge   = btn_q & ~btn_prev;
  assign lvl_m1     = level - LW'(1);
  assign last_step  = (LW'(idx) == lvl_m1);
  assign colour     = CW'(lfsr % 16'(N_CH));
  assign exp_oh     = onehot(mem[idx]);
  assign state      = st;

  // Speed-up halves the on-time every four rounds, capped at an eighth, never below one clock.
  always_comb begin
    shamt = 32'(lvl_m1) >> 2;
    if (shamt > 32'd3) shamt = 32'd3;
    t_on = mode_r ? (32'(ON_CYC) >> shamt) : 32'(ON_CYC);
    if (t_on == 32'd0) t_on = 32'd1;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      st         <= S_IDLE;
      lfsr       <= LFSR_SEED;
      enter_q    <= 1'b0;
      enter_prev <= 1'b0;
      btn_q      <= '0;
      btn_prev   <= '0;
      idx        <= '0;
      timer      <= '0;
      level      <= '0;
      score      <= '0;
      win        <= 1'b0;
      lose       <= 1'b0;
      end_time   <= 1'b0;
      mode_r     <= 1'b0;
    end else begin
      st         <= st_n;
      lfsr       <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      enter_q    <= enter;
      enter_prev <= enter_q;
      btn_q      <= btn;
      btn_prev   <= btn_q;
      idx        <= idx_n;
      timer      <= timer_n;
      level      <= level_n;
      score      <= score_n;
      win        <= win_n;
      lose       <= lose_n;
      end_time   <= end_n;
      mode_r     <= mode_n;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (st == S_GEN) mem[IW'(lvl_m1)] <= colour;
  end

  always_comb begin
    st_n    = st;
    idx_n   = idx;
    timer_n = timer;
    level_n = level;
    score_n = score;
    win_n   = win;
    lose_n  = lose;
    end_n   = end_time;
    mode_n  = mode_r;
    leds    = '0;

    case (st)
      S_GEN: begin
        idx_n   = '0;
        timer_n = '0;
        st_n    = S_PLAY_ON;
      end
      S_PLAY_ON: begin
        leds = exp_oh;
        if (timer >= t_on - 32'd1) begin
          timer_n = '0;
          st_n    = S_PLAY_OFF;
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      S_PLAY_OFF: begin
        if (timer >= OFF_LAST) begin
          timer_n = '0;
          if (last_step) begin
            idx_n = '0;
            st_n  = S_WAIT_IN;
          end else begin
            idx_n = idx + IW'(1);
            st_n  = S_PLAY_ON;
          end
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      S_WAIT_IN: begin
        leds = btn;
        // A press seen on the final timeout cycle still counts.
        if (btn_edge != '0) begin
          if (btn_edge != exp_oh) begin
            lose_n = 1'b1;
            st_n   = S_LOSE;
          end else begin
            timer_n = '0;
            if (last_step) st_n = S_CHECK;
            else           idx_n = idx + IW'(1);
          end
        end else if (timer >= TO_LAST) begin
          lose_n = 1'b1;
          end_n  = 1'b1;
          st_n   = S_LOSE;
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      S_CHECK: begin
        score_n = level;
        if (level == LW'(MAX_LEN)) begin
          win_n = 1'b1;
          st_n  = S_WIN;
        end else begin
          level_n = level + LW'(1);
          st_n    = S_GEN;
        end
      end
      default: begin
        if (st == S_WIN)  leds = '1;
        if (st == S_LOSE) leds = exp_oh;
        if (enter_edge) begin
          level_n = LW'(1);
          score_n = '0;
          win_n   = 1'b0;
          lose_n  = 1'b0;
          end_n   = 1'b0;
          mode_n  = mode;
          st_n    = S_GEN;
        end
      end
    endcase
  end

endmodule
`default_nettype wire
